// File: rtl/sar_afe_model.sv
// sar_afe_model
// Digital stand-in for the SAR ADC analog front end (sample-and-hold,
// capacitive DAC and differential comparator). The "analog" input is a code
// in LSB units. Sits opposite the adc controller's analog interface.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   vin_i        input level, unsigned LSBs
//   offset_i     signed comparator offset (two's complement, RESOLUTION+1 bits)
//   sample_i     1 = track, 0 = hold
//   dac_p_i      trial code
//   dac_n_i      complementary trial code (expected ~dac_p_i)
//   comp_p_o     decision: held >= trial code
//   comp_n_o     decision: held <  trial code
//   held_o       held, offset-adjusted, clamped level
//   err_o        sticky: complementary code mismatch seen while holding
//   conv_cnt_o   number of hold phases entered (wraps)
//
// state  | meaning
// TRACK  | held level follows vin_i + offset_i, comparator forced to 0/0
// HOLD   | held level frozen, comparator resolves against dac_p_i
module sar_afe_model #(
  parameter int RESOLUTION   = 8,
  parameter int COMP_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [RESOLUTION-1:0] vin_i,
  input  logic [RESOLUTION:0]   offset_i,
  input  logic                  sample_i,
  input  logic [RESOLUTION-1:0] dac_p_i,
  input  logic [RESOLUTION-1:0] dac_n_i,
  output logic                  comp_p_o,
  output logic                  comp_n_o,
  output logic [RESOLUTION-1:0] held_o,
  output logic                  err_o,
  output logic [15:0]           conv_cnt_o
);

  typedef enum logic {ST_TRACK = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t                    r_state;
  logic [RESOLUTION-1:0]     r_held;
  logic                      r_err;
  logic [15:0]               r_conv_cnt;
  logic [COMP_LATENCY-1:0]   r_pipe_p;
  logic [COMP_LATENCY-1:0]   r_pipe_n;

  logic signed [RESOLUTION+1:0] w_sum;
  logic [RESOLUTION-1:0]        w_clamped;
  logic                         w_mismatch;
  logic                         w_ge;
  logic                         w_raw_p;
  logic                         w_raw_n;

  // Two guard bits: one for the carry above full scale, one for the sign.
  assign w_sum = $signed({2'b00, vin_i}) + $signed({offset_i[RESOLUTION], offset_i});

  always_comb begin
    w_clamped = w_sum[RESOLUTION-1:0];
    if (w_sum[RESOLUTION+1]) begin
      w_clamped = '0;
    end else if (w_sum[RESOLUTION]) begin
      w_clamped = '1;
    end
  end

  assign w_mismatch = (dac_n_i != ~dac_p_i);
  assign w_ge       = (r_held >= dac_p_i);

  // The hold phase starts on the very edge sample_i falls, so the decision
  // is keyed on sample_i rather than the registered state; r_held already
  // carries the value captured at the last tracking edge.
  assign w_raw_p = ~sample_i & ~w_mismatch & w_ge;
  assign w_raw_n = ~sample_i & ~w_mismatch & ~w_ge;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_TRACK;
      r_held     <= '0;
      r_err      <= 1'b0;
      r_conv_cnt <= '0;
      r_pipe_p   <= '0;
      r_pipe_n   <= '0;
    end else begin
      case (r_state)
        ST_TRACK: begin
          if (!sample_i) begin
            r_state    <= ST_HOLD;
            r_conv_cnt <= r_conv_cnt + 16'd1;
          end
        end
        ST_HOLD: begin
          if (sample_i) begin
            r_state <= ST_TRACK;
          end
        end
        default: r_state <= ST_TRACK;
      endcase

      if (sample_i) begin
        r_held <= w_clamped;
      end

      if (!sample_i && w_mismatch) begin
        r_err <= 1'b1;
      end

      // Stages shift every cycle so pending decisions drain after HOLD ends.
      r_pipe_p[0] <= w_raw_p;
      r_pipe_n[0] <= w_raw_n;
      for (int i = 1; i < COMP_LATENCY; i++) begin
        r_pipe_p[i] <= r_pipe_p[i-1];
        r_pipe_n[i] <= r_pipe_n[i-1];
      end
    end
  end

  assign comp_p_o   = r_pipe_p[COMP_LATENCY-1];
  assign comp_n_o   = r_pipe_n[COMP_LATENCY-1];
  assign held_o     = r_held;
  assign err_o      = r_err;
  assign conv_cnt_o = r_conv_cnt;

endmodule

// File: tb/tb_sar_afe_model.sv
module tb_sar_afe_model;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] vin_i = 8'h55;
  logic [8:0] offset_i = 9'd0;
  logic       sample_i = 1'b1;
  logic [7:0] dac_p_i = 8'h00;
  logic [7:0] dac_n_i = 8'hFF;

  logic       c1_p, c1_n, e1;
  logic [7:0] h1;
  logic [15:0] n1;
  logic       c3_p, c3_n, e3;
  logic [7:0] h3;
  logic [15:0] n3;

  int n_checks = 0;
  int n_errors = 0;

  // expected raw decisions {p,n}, one entry per clock edge
  logic [1:0] q1[$];
  logic [1:0] q3[$];

  // reference model
  logic        m_track;
  logic [7:0]  m_held;
  logic        m_err;
  logic [15:0] m_cnt;

  logic [7:0] sar_res;
  logic [7:0] trial;
  logic [7:0] exp_bits;

  always #5 clk_i = ~clk_i;

  sar_afe_model #(.RESOLUTION(8), .COMP_LATENCY(1)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .vin_i(vin_i), .offset_i(offset_i),
    .sample_i(sample_i), .dac_p_i(dac_p_i), .dac_n_i(dac_n_i),
    .comp_p_o(c1_p), .comp_n_o(c1_n), .held_o(h1), .err_o(e1), .conv_cnt_o(n1)
  );

  sar_afe_model #(.RESOLUTION(8), .COMP_LATENCY(3)) u_dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .vin_i(vin_i), .offset_i(offset_i),
    .sample_i(sample_i), .dac_p_i(dac_p_i), .dac_n_i(dac_n_i),
    .comp_p_o(c3_p), .comp_n_o(c3_n), .held_o(h3), .err_o(e3), .conv_cnt_o(n3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] f_clamp(input logic [7:0] v, input logic [8:0] o);
    int s;
    s = int'(v) + int'($signed(o));
    if (s < 0) return 8'h00;
    if (s > 255) return 8'hFF;
    return s[7:0];
  endfunction

  task automatic model_reset();
    m_track = 1'b1;
    m_held  = 8'h00;
    m_err   = 1'b0;
    m_cnt   = 16'h0000;
    q1.delete();
    q3.delete();
    q3.push_back(2'b00);
    q3.push_back(2'b00);
  endtask

  task automatic do_reset(input int ncyc, input logic s);
    @(negedge clk_i);
    rst_i = 1'b1; sample_i = s; vin_i = 8'h55; offset_i = 9'd0;
    dac_p_i = 8'h00; dac_n_i = 8'hFF;
    repeat (ncyc) @(posedge clk_i);
    #1;
    model_reset();
    check("rst_comp_p1", c1_p, 0);
    check("rst_comp_n1", c1_n, 0);
    check("rst_held1", h1, 0);
    check("rst_err1", e1, 0);
    check("rst_cnt1", n1, 0);
    check("rst_comp_p3", c3_p, 0);
    check("rst_comp_n3", c3_n, 0);
    check("rst_held3", h3, 0);
    check("rst_err3", e3, 0);
    check("rst_cnt3", n3, 0);
  endtask

  task automatic step(input logic s, input logic [7:0] v, input logic [8:0] o,
                      input logic [7:0] dp, input logic [7:0] dn);
    logic [1:0] ex;
    logic [1:0] got;
    @(negedge clk_i);
    rst_i = 1'b0; sample_i = s; vin_i = v; offset_i = o; dac_p_i = dp; dac_n_i = dn;
    ex = 2'b00;
    if (!s) begin
      if (dn != ~dp) m_err = 1'b1;
      else ex = (m_held >= dp) ? 2'b10 : 2'b01;
    end
    q1.push_back(ex);
    q3.push_back(ex);
    if (s) m_held = f_clamp(v, o);
    else if (m_track) m_cnt = m_cnt + 16'd1;
    m_track = s;
    @(posedge clk_i);
    #1;
    got = q1.pop_front();
    check("comp_p1", c1_p, got[1]);
    check("comp_n1", c1_n, got[0]);
    if (q3.size() > 0) begin
      got = q3.pop_front();
      check("comp_p3", c3_p, got[1]);
      check("comp_n3", c3_n, got[0]);
    end else begin
      check("q3_underflow", 1, 0);
    end
    check("held1", h1, m_held);
    check("held3", h3, m_held);
    check("err1", e1, m_err);
    check("err3", e3, m_err);
    check("cnt1", n1, m_cnt);
    check("cnt3", n3, m_cnt);
  endtask

  initial begin
    // reset, 2 cycles, vin 0x55
    do_reset(2, 1'b1);

    // binary search, vin 0xAD, offset 0
    exp_bits = 8'b1010_1101;
    step(1'b1, 8'hAD, 9'd0, 8'h00, 8'hFF);
    step(1'b1, 8'hAD, 9'd0, 8'h00, 8'hFF);
    sar_res = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      trial = sar_res | (8'h01 << b);
      step(1'b0, 8'hAD, 9'd0, trial, ~trial);
      check("sar_bit", c1_p, exp_bits[b]);
      if (c1_p) sar_res = trial;
    end
    check("sar_result", sar_res, 8'hAD);
    check("sar_conv_cnt", n1, 16'd1);
    step(1'b1, 8'hAD, 9'd0, 8'h00, 8'hFF);
    step(1'b1, 8'hAD, 9'd0, 8'h00, 8'hFF);

    // boundaries
    step(1'b1, 8'hFF, 9'd0, 8'h00, 8'hFF);
    step(1'b0, 8'hFF, 9'd0, 8'hFF, 8'h00);
    check("bnd_ff_ff_p", c1_p, 1);
    step(1'b1, 8'h00, 9'd0, 8'h00, 8'hFF);
    step(1'b0, 8'h00, 9'd0, 8'h00, 8'hFF);
    check("bnd_00_00_p", c1_p, 1);
    step(1'b0, 8'h00, 9'd0, 8'h01, 8'hFE);
    check("bnd_00_01_n", c1_n, 1);
    step(1'b1, 8'h80, 9'd0, 8'h00, 8'hFF);
    step(1'b0, 8'h80, 9'd0, 8'h80, 8'h7F);
    check("bnd_80_80_p", c1_p, 1);

    // offset and clamp
    step(1'b1, 8'h80, 9'h1FF, 8'h00, 8'hFF);
    check("ofs_m1_held", h1, 8'h7F);
    step(1'b0, 8'h80, 9'h1FF, 8'h80, 8'h7F);
    check("ofs_m1_comp_n", c1_n, 1);
    step(1'b1, 8'hFE, 9'd5, 8'h00, 8'hFF);
    check("clamp_hi_held", h1, 8'hFF);
    step(1'b1, 8'h02, 9'h1FC, 8'h00, 8'hFF);
    check("clamp_lo_held", h1, 8'h00);

    // hold integrity and mismatch
    step(1'b1, 8'h10, 9'd0, 8'h00, 8'hFF);
    step(1'b0, 8'h10, 9'd0, 8'h20, 8'hDF);
    step(1'b0, 8'hF0, 9'd0, 8'h08, 8'hF7);
    check("hold_frozen", h1, 8'h10);
    step(1'b0, 8'hF0, 9'd0, 8'h40, 8'h40);
    check("mm_comp_p", c1_p, 0);
    check("mm_comp_n", c1_n, 0);
    check("mm_err", e1, 1);
    step(1'b0, 8'hF0, 9'd0, 8'h08, 8'hF7);
    check("err_sticky_p", c1_p, 1);
    check("err_sticky", e1, 1);
    step(1'b1, 8'hF0, 9'd0, 8'h00, 8'hFF);
    step(1'b1, 8'hF0, 9'd0, 8'h00, 8'hFF);
    check("err_sticky_trk", e1, 1);

    // latency 3
    step(1'b1, 8'h90, 9'd0, 8'h00, 8'hFF);
    step(1'b0, 8'h90, 9'd0, 8'h80, 8'h7F);
    check("lat3_e1_p", c3_p, 0);
    step(1'b0, 8'h90, 9'd0, 8'hFF, 8'h00);
    check("lat3_e2_p", c3_p, 0);
    step(1'b0, 8'h90, 9'd0, 8'hFF, 8'h00);
    check("lat3_e3_p", c3_p, 1);
    check("lat3_e3_n", c3_n, 0);

    // reset mid-hold with pending decisions
    do_reset(1, 1'b0);
    step(1'b0, 8'h90, 9'd0, 8'h00, 8'hFF);
    check("post_rst_track_cnt", n3, 16'd1);
    check("post_rst_comp_p1", c1_p, 1);
    step(1'b1, 8'h33, 9'd0, 8'h00, 8'hFF);
    step(1'b1, 8'h33, 9'd0, 8'h00, 8'hFF);
    step(1'b1, 8'h33, 9'd0, 8'h00, 8'hFF);

    // conv_cnt wrap
    @(negedge clk_i);
    force u_dut1.r_conv_cnt = 16'hFFFF;
    force u_dut3.r_conv_cnt = 16'hFFFF;
    #1;
    release u_dut1.r_conv_cnt;
    release u_dut3.r_conv_cnt;
    m_cnt = 16'hFFFF;
    step(1'b0, 8'h33, 9'd0, 8'h33, 8'hCC);
    check("wrap_cnt1", n1, 16'h0000);
    check("wrap_cnt3", n3, 16'h0000);
    step(1'b1, 8'h33, 9'd0, 8'h00, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sar_afe_model.md
# sar_afe_model

Synthesizable digital stand-in for the analog front end of the SAR ADC: sample-and-hold, capacitive DAC and differential comparator. It sits on the opposite side of the `adc` controller's analog interface. It consumes `sample`/`dac_p`/`dac_n` and answers with `comp_p`/`comp_n`. This enables closed-loop simulation and FPGA bring-up of the controller without ngspice co-simulation. The "analog" input is a digital code in LSB units.

## Interface
- `RESOLUTION`, 8: DAC/input code width; must match the controller.
- `COMP_LATENCY`, 1: comparator decision pipeline depth in cycles; legal range 1..4.
- `clk_i` in 1: single clock; all logic on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `vin_i` in RESOLUTION: input level, unsigned, in LSBs.
- `offset_i` in RESOLUTION+1: signed comparator offset in LSBs, two's complement.
- `sample_i` in 1: track/hold control; connect to controller `sample_o`.
- `dac_p_i` in RESOLUTION: trial code; connect to controller `dac_p_o`.
- `dac_n_i` in RESOLUTION: complementary trial code; connect to `dac_n_o`.
- `comp_p_o` out 1: decision, held input ≥ trial code.
- `comp_n_o` out 1: decision, held input < trial code.
- `held_o` out RESOLUTION: currently held (offset-adjusted, clamped) level.
- `err_o` out 1: sticky, set when `dac_n_i != ~dac_p_i` during hold.
- `conv_cnt_o` out 16: number of hold phases entered, wrapping.

## Operation
- Reset values: `comp_p_o`=0, `comp_n_o`=0, `held_o`=0, `err_o`=0, `conv_cnt_o`=0. The comparator pipeline is cleared to 0/0.
- Two-state FSM: TRACK and HOLD. Reset enters TRACK.
- TRACK (`sample_i`=1):
  - Every cycle, held register ← clamp(`vin_i` + sext(`offset_i`), 0, 2^RESOLUTION−1).
  - The sum is computed at RESOLUTION+2 bits signed, then saturated.
  - The comparator is in reset: pipeline inputs are forced to 0/0.
- TRACK→HOLD on the first edge where `sample_i`=0.
  - The held value is the one captured at the last edge with `sample_i`=1.
  - `conv_cnt_o` increments by 1, wrapping 0xFFFF→0.
- HOLD (`sample_i`=0):
  - The held register is frozen; `vin_i` and `offset_i` are ignored.
  - Each cycle the raw decision is computed: p = (held ≥ `dac_p_i`), n = ~p.
  - If `dac_n_i != ~dac_p_i`, the raw decision is forced to 0/0 and `err_o` is set.
  - Valid raw decisions are always one-hot.
- HOLD→TRACK on any edge with `sample_i`=1. The pipeline input returns to 0/0.
- `err_o` clears only on `rst_i`.
- Comparisons are unsigned, full RESOLUTION width. Equality resolves to `comp_p_o`=1.
- `rst_i` has priority over all events. Reset mid-HOLD discards the held value and pending decisions, and the FSM returns to TRACK.

## Timing
- Decision latency is COMP_LATENCY edges.
  - The raw decision for `dac_p_i`/`dac_n_i` sampled at edge N appears on `comp_p_o`/`comp_n_o` after edge N+COMP_LATENCY−1.
  - With COMP_LATENCY=1 it is valid during the cycle following edge N.
- Pipeline stages shift every cycle regardless of state.
  - After HOLD→TRACK, the last COMP_LATENCY−1 HOLD decisions still drain out.
  - The outputs then read 0/0.
- `held_o` updates one cycle after the `vin_i`/`offset_i` change while in TRACK. It is constant throughout HOLD.
- `conv_cnt_o` updates on the TRACK→HOLD edge itself.
- No handshake: the block responds to whatever trial code is presented. A new code every cycle is supported at full throughput.

## Test plan
- Reset: assert `rst_i` for 2 cycles with `vin_i`=0x55.
  - All outputs read 0, including `comp_p_o`=`comp_n_o`=0.
- Binary search with `adc` in the loop, COMP_LATENCY=1, `vin_i`=0xAD, `offset_i`=0:
  - Decision sequence is 1,0,1,0,1,1,0,1.
  - Controller `result_o`=0xAD and `conv_cnt_o`=1.
- Boundaries during HOLD, presenting `dac_n_i`=~`dac_p_i`:
  - `vin_i`=0xFF vs dac 0xFF → comp_p=1.
  - `vin_i`=0x00 vs 0x00 → comp_p=1.
  - `vin_i`=0x00 vs 0x01 → comp_n=1.
  - `vin_i`=0x80 vs 0x80 → comp_p=1.
- Offset and clamp:
  - `vin_i`=0x80, `offset_i`=−1 → `held_o`=0x7F; dac 0x80 → comp_n=1.
  - `vin_i`=0xFE, `offset_i`=+5 → `held_o`=0xFF.
  - `vin_i`=0x02, `offset_i`=−4 → `held_o`=0x00.
- Hold integrity and mismatch:
  - Change `vin_i` 0x10→0xF0 mid-HOLD → `held_o` stays 0x10.
  - Present `dac_p_i`=0x40 with `dac_n_i`=0x40 → that decision is 0/0 and `err_o`=1.
  - `err_o` stays 1 through later valid decisions until `rst_i`.
- Latency and reset mid-operation, COMP_LATENCY=3:
  - A decision appears 3 edges after its code.
  - Assert `rst_i` mid-HOLD → next cycle outputs 0/0, `held_o`=0, FSM in TRACK.
  - A 0xFFFF→0 wrap check on `conv_cnt_o` is done by forcing its count.
